// File: rtl/rr_arbiter_four_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding
// and requester count / index width constants.
package rr_arbiter_four_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search over four requesters: returns the first
// requesting, non-excluded index starting at ptr and wrapping modulo four.
module rr_pick4
    import rr_arbiter_four_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [NUM_REQ-1:0] avail;
    logic [IDX_W-1:0]   cand;

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        avail = req & ~exclude;
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (avail[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_four.sv
// Four-way round-robin arbiter driving a shared 4:1 data path.
// Define RR_ARB_TIMEOUT_EN to bound each ownership to HOLD_MAX cycles when others wait.
module rr_arbiter_four
    import rr_arbiter_four_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   in,
    output logic [3:0]            grant,
    output logic [1:0]            sel,
    output logic                  valid,
    output logic [DATA_W-1:0]     out
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter_four: HOLD_MAX must be within 2..255");
    end

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;

    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_excl;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    logic               owner_drop;
    logic               timeout;
    logic               release_now;

    logic [DATA_W-1:0]  words [NUM_REQ];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q, hold_d;
    logic       hold_done;

    assign hold_done = (hold_q == HOLD_LAST);
    assign timeout   = hold_done && (|(req & ~grant_q));

    // Counter clears on any owner change and when an uncontested owner hits the limit.
    always_comb begin
        hold_d = '0;
        if (state_q == BUSY && !release_now && !hold_done) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign owner_drop  = !req[sel_q];
    assign release_now = (state_q == BUSY) && (owner_drop || timeout);

    // While busy the search starts after the owner and skips it, so a
    // releasing owner is always considered last.
    assign pick_ptr  = (state_q == BUSY) ? sel_q + 2'd1 : ptr_q;
    assign pick_excl = (state_q == BUSY) ? grant_q : '0;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .found   (pick_found),
        .index   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_d = sel_q + 2'd1;
                    if (pick_found) begin
                        grant_d = NUM_REQ'(1) << pick_idx;
                        sel_d   = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        valid_d = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = in[i*DATA_W +: DATA_W];
        end
    end

    assign out   = valid_q ? words[sel_q] : '0;
    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: doc/rr_arbiter_four.md
RR_ARBITER_FOUR -- requirements
Module: rr_arbiter_four

Interface
REQ-001 Parameter DATA_W, default 8, width of each requester data word.
REQ-002 Parameter HOLD_MAX, default 4, maximum consecutive grant cycles per owner when the timeout feature is compiled in; legal range 2..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  request per requester; bit i asserted while requester i wants the shared 4:1 path.
REQ-006 in  input  4*DATA_W  requester data; word i is in[i*DATA_W +: DATA_W].
REQ-007 grant  output  4  one-hot (or zero) current owner, registered.
REQ-008 sel  output  2  binary owner index driving the 4:1 selection, registered; equals encode(grant) when valid.
REQ-009 valid  output  1  registered; high while a requester owns the path.
REQ-010 out  output  DATA_W  in word selected by sel; combinational from sel and in; zero when valid low.

Function
REQ-011 The block SHALL have two states: IDLE (no owner) and BUSY (owner = sel).
REQ-012 Priority pointer ptr (2 bits) SHALL give the first index searched; the search order is ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-013 In IDLE with req != 0 at an edge, the block SHALL enter BUSY with owner = first requesting index in pointer order; grant/sel/valid visible the cycle after req is first sampled (latency 1).
REQ-014 In IDLE with req == 0, all outputs SHALL hold their idle values (grant 0, valid 0, sel unchanged).
REQ-015 In BUSY while req[owner] == 1 (and no timeout), owner SHALL stay unchanged.
REQ-016 In BUSY when req[owner] == 0 at an edge, release SHALL occur: ptr <= owner+1 (3 wraps to 0); if any other req bit is high, the new owner is chosen by REQ-012 using the updated ptr and takes effect next cycle with no idle bubble; otherwise state returns to IDLE.
REQ-017 A requester dropping and re-raising req in the same cycle as release SHALL not retain ownership; it is considered last in the next search.
REQ-018 Requests arriving or dropping for non-owners SHALL not affect the current owner.
REQ-019 grant SHALL never have more than one bit set; valid == (grant != 0) at all times.
REQ-020 sel SHALL keep its last value in IDLE; out is forced to zero.

Reset
REQ-021 On rst at a clock edge: state IDLE, grant 0, sel 0, valid 0, ptr 0, hold counter 0; req ignored that cycle.
REQ-022 Reset asserted during BUSY SHALL drop ownership on the same edge; first arbitration after reset uses ptr 0.

Configuration
REQ-023 Macro RR_ARB_TIMEOUT_EN SHALL compile in a hold counter (8 bits) that counts owner cycles in BUSY.
REQ-024 With RR_ARB_TIMEOUT_EN: when the counter reaches HOLD_MAX-1 and at least one other req bit is high, the block SHALL force a release as in REQ-016 even though req[owner] is high; counter clears on every owner change; if no other requester, the owner keeps the grant and the counter clears.
REQ-025 Without RR_ARB_TIMEOUT_EN: no counter exists; an owner holds the grant until it drops req; HOLD_MAX is unused.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, BUSY), the requester count constant (4) and the index width constant (2).
REQ-027 One combinational sub-module rr_pick4 SHALL implement the rotate-priority search: inputs req[3:0], ptr[1:0], exclude mask; outputs found and index[1:0].
REQ-028 The 4:1 data selection SHALL be a plain indexed select inside rr_arbiter_four.

Verification
REQ-029 After reset, req=4'b0100 for one cycle then held -> next cycle grant=4'b0100, sel=2, valid=1, out=in word 2.
REQ-030 req=4'b1111 held, each owner drops req for one cycle after 2 grant cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
REQ-031 Owner 3 releases with req=4'b0000 -> valid=0 next cycle, ptr=0; then req=4'b0011 -> grant=4'b0001.
REQ-032 RR_ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held -> owner 0 for exactly 4 cycles, then owner 1 for 4 cycles, alternating; with req=4'b0001 only -> owner 0 never released.
REQ-033 rst asserted while owner=2 and req=4'b1111 -> next cycle grant=0, valid=0, sel=0; after rst deasserts, first grant goes to index 0.
REQ-034 Assertions throughout all scenarios: grant one-hot or zero, valid==(grant!=0), out==0 whenever valid==0.
